// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with a sequential clear-on-reset engine
//   clk      - clock, all state updates on the rising edge
//   rst_n    - asynchronous active-low reset, restarts the clear sequence
//   ready    - high once every register has been cleared; writes accepted
//   we/waddr/wdata - datapath write port
//   raddr/rdata    - NRD packed combinational read ports (optionally bypassed)
//   dbg_addr/dbg_data - debug read port, always shows the stored value
//   start/in       - host load into register 0, wins over we on register 0
module regfile_mp #(
   parameter int WIDTH  = 16,
   parameter int AWIDTH = 5,
   parameter int NRD    = 3,
   parameter int BYPASS = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  ready,
   input  logic                  we,
   input  logic [AWIDTH-1:0]     waddr,
   input  logic [WIDTH-1:0]      wdata,
   input  logic [NRD*AWIDTH-1:0] raddr,
   output logic [NRD*WIDTH-1:0]  rdata,
   input  logic [AWIDTH-1:0]     dbg_addr,
   output logic [WIDTH-1:0]      dbg_data,
   input  logic                  start,
   input  logic [WIDTH-1:0]      in
);
   localparam int DEPTH = 2 ** AWIDTH;
   typedef enum logic {CLEAR, RUN} state_t;
   state_t              state_q, state_d;
   logic [AWIDTH-1:0]   clr_ptr_q, clr_ptr_d;
   logic [WIDTH-1:0]    mem_q [DEPTH];
   logic                run, a_en, b_en;
   logic [AWIDTH-1:0]   a_addr, ra;
   logic [WIDTH-1:0]    a_data;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q   <= CLEAR;
         clr_ptr_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_ptr_q <= clr_ptr_d;
      end
   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      if (state_q == CLEAR) begin
         clr_ptr_d = clr_ptr_q + 1'b1;
         if (&clr_ptr_q) state_d = RUN;
      end
   end
   // Port A is shared: clear writes during CLEAR, host load in RUN.
   // Port B is the datapath write, suppressed when the host load owns register 0.
   always_comb begin
      run    = state_q == RUN;
      ready  = run;
      a_en   = !run || start;
      a_addr = run ? '0 : clr_ptr_q;
      a_data = run ? in : '0;
      b_en   = run && we && !(start && waddr == '0);
   end
   // Array deliberately has no reset; the clear engine zeroes it instead.
   always_ff @(posedge clk) begin
      if (a_en) mem_q[a_addr] <= a_data;
      if (b_en) mem_q[waddr] <= wdata;
   end
   always_comb begin
      rdata = '0;
      ra    = '0;
      for (int i = 0; i < NRD; i++) begin
         ra = raddr[i*AWIDTH +: AWIDTH];
         rdata[i*WIDTH +: WIDTH] = !run ? '0 :
            (BYPASS != 0 && a_en && ra == a_addr) ? a_data :
            (BYPASS != 0 && b_en && ra == waddr)  ? wdata  : mem_q[ra];
      end
      dbg_data = run ? mem_q[dbg_addr] : '0;
   end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: table-driven, directed and random checks of regfile_mp against a reference model
module tb_regfile_mp;
   localparam int W = 16, AW = 5, NRD = 3, DEPTH = 32;
   logic clk = 0, rst_n = 0, we = 0, start = 0;
   logic [AW-1:0] waddr = '0, dbg_addr = '0;
   logic [W-1:0] wdata = '0, in_d = '0;
   logic [AW-1:0] ra [NRD];
   logic [NRD*AW-1:0] raddr;
   logic [NRD*W-1:0] rdata, rdata_nb;
   logic [W-1:0] dbg_data, dbg_nb;
   logic ready, ready_nb;
   int checks = 0, errors = 0;
   logic [W-1:0] m [DEPTH];
   bit rdy_m;
   int clr_cnt;

   assign raddr = {ra[2], ra[1], ra[0]};
   always #5 clk = ~clk;

   regfile_mp #(.WIDTH(W), .AWIDTH(AW), .NRD(NRD), .BYPASS(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .ready(ready), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr(raddr), .rdata(rdata), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
      .start(start), .in(in_d));
   regfile_mp #(.WIDTH(W), .AWIDTH(AW), .NRD(NRD), .BYPASS(0)) u_nb (
      .clk(clk), .rst_n(rst_n), .ready(ready_nb), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr(raddr), .rdata(rdata_nb), .dbg_addr(dbg_addr), .dbg_data(dbg_nb),
      .start(start), .in(in_d));

   typedef struct {
      logic we, start;
      logic [AW-1:0] waddr, ra0, ra1, dbg;
      logic [W-1:0] wdata, in_v, r0, r1, nb0, nb1, dbg_e;
   } vec_t;
   vec_t tbl [8];

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
      if (!rdy_m) return '0;
      if (byp && start && a == '0) return in_d;
      if (byp && we && a == waddr) return wdata;
      return m[a];
   endfunction

   task automatic model_reset();
      rdy_m = 0;
      clr_cnt = 0;
      for (int i = 0; i < DEPTH; i++) m[i] = '0;
   endtask

   task automatic model_step();
      if (!rdy_m) begin
         clr_cnt++;
         if (clr_cnt == DEPTH) rdy_m = 1;
      end else begin
         if (we) m[waddr] = wdata;
         if (start) m[0] = in_d;
      end
   endtask

   task automatic check_all();
      chk("ready", W'(ready), W'(rdy_m));
      chk("ready_nb", W'(ready_nb), W'(rdy_m));
      for (int i = 0; i < NRD; i++) begin
         chk($sformatf("rdata%0d", i), rdata[i*W +: W], exp_rd(ra[i], 1));
         chk($sformatf("rdata_nb%0d", i), rdata_nb[i*W +: W], exp_rd(ra[i], 0));
      end
      chk("dbg", dbg_data, rdy_m ? m[dbg_addr] : '0);
      chk("dbg_nb", dbg_nb, rdy_m ? m[dbg_addr] : '0);
   endtask

   task automatic tick();
      @(negedge clk);
      check_all();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic rand_in();
      we = 1'($urandom_range(0, 1));
      start = ($urandom_range(0, 3) == 0);
      waddr = $urandom_range(0, 1) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, 31));
      wdata = W'($urandom);
      in_d = W'($urandom);
      for (int i = 0; i < NRD; i++)
         ra[i] = $urandom_range(0, 1) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, 31));
      dbg_addr = AW'($urandom_range(0, 31));
   endtask

   task automatic idle();
      we = 0;
      start = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{we:1, start:0, waddr:5, ra0:5, ra1:5, dbg:5, wdata:16'h1234, in_v:0,
                 r0:16'h1234, r1:16'h1234, nb0:0, nb1:0, dbg_e:0};
      tbl[1] = '{we:0, start:0, waddr:0, ra0:5, ra1:5, dbg:5, wdata:0, in_v:0,
                 r0:16'h1234, r1:16'h1234, nb0:16'h1234, nb1:16'h1234, dbg_e:16'h1234};
      tbl[2] = '{we:1, start:1, waddr:0, ra0:0, ra1:0, dbg:0, wdata:16'hBEEF, in_v:16'h00FF,
                 r0:16'h00FF, r1:16'h00FF, nb0:0, nb1:0, dbg_e:0};
      tbl[3] = '{we:0, start:0, waddr:0, ra0:0, ra1:0, dbg:0, wdata:0, in_v:0,
                 r0:16'h00FF, r1:16'h00FF, nb0:16'h00FF, nb1:16'h00FF, dbg_e:16'h00FF};
      tbl[4] = '{we:1, start:1, waddr:9, ra0:9, ra1:9, dbg:0, wdata:16'h0009, in_v:16'h0007,
                 r0:16'h0009, r1:16'h0009, nb0:0, nb1:0, dbg_e:16'h00FF};
      tbl[5] = '{we:0, start:0, waddr:0, ra0:0, ra1:9, dbg:9, wdata:0, in_v:0,
                 r0:16'h0007, r1:16'h0009, nb0:16'h0007, nb1:16'h0009, dbg_e:16'h0009};
      tbl[6] = '{we:1, start:0, waddr:2, ra0:2, ra1:2, dbg:2, wdata:16'h5555, in_v:0,
                 r0:16'h5555, r1:16'h5555, nb0:0, nb1:0, dbg_e:0};
      tbl[7] = '{we:0, start:0, waddr:0, ra0:2, ra1:2, dbg:2, wdata:0, in_v:0,
                 r0:16'h5555, r1:16'h5555, nb0:16'h5555, nb1:16'h5555, dbg_e:16'h5555};
      for (int i = 0; i < NRD; i++) ra[i] = '0;
      model_reset();
      #2;
      chk("ready_in_reset", W'(ready), 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1;
      // writes during CLEAR must be dropped
      we = 1;
      waddr = 3;
      wdata = 16'hAAAA;
      for (int i = 0; i < NRD; i++) ra[i] = 3;
      dbg_addr = 3;
      for (int c = 0; c < DEPTH; c++) tick();
      idle();
      #3;
      chk("ready_after_clear", W'(ready), 1);
      chk("reg3_after_clear", rdata[W-1:0], 0);
      tick();
      for (int v = 0; v < 8; v++) begin
         we = tbl[v].we;
         start = tbl[v].start;
         waddr = tbl[v].waddr;
         wdata = tbl[v].wdata;
         in_d = tbl[v].in_v;
         ra[0] = tbl[v].ra0;
         ra[1] = tbl[v].ra1;
         ra[2] = tbl[v].ra0;
         dbg_addr = tbl[v].dbg;
         #3;
         chk($sformatf("tbl%0d_r0", v), rdata[0 +: W], tbl[v].r0);
         chk($sformatf("tbl%0d_r1", v), rdata[W +: W], tbl[v].r1);
         chk($sformatf("tbl%0d_nb0", v), rdata_nb[0 +: W], tbl[v].nb0);
         chk($sformatf("tbl%0d_nb1", v), rdata_nb[W +: W], tbl[v].nb1);
         chk($sformatf("tbl%0d_dbg", v), dbg_data, tbl[v].dbg_e);
         tick();
      end
      idle();
      for (int a = 0; a < DEPTH; a++) begin
         we = 1;
         waddr = AW'(a);
         wdata = W'(a);
         tick();
      end
      idle();
      ra[0] = 31;
      ra[1] = 0;
      ra[2] = 31;
      #3;
      chk("fill_r0", rdata[0 +: W], 16'd31);
      chk("fill_r1", rdata[W +: W], 16'd0);
      chk("fill_r2", rdata[2*W +: W], 16'd31);
      tick();
      for (int c = 0; c < 300; c++) begin
         rand_in();
         tick();
      end
      // asynchronous reset in the middle of a cycle
      rand_in();
      #2;
      rst_n = 0;
      #1;
      chk("ready_async_drop", W'(ready), 0);
      chk("ready_nb_async_drop", W'(ready_nb), 0);
      chk("rdata0_in_reset", rdata[0 +: W], 0);
      chk("dbg_in_reset", dbg_data, 0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1;
      for (int c = 0; c < DEPTH; c++) begin
         rand_in();
         tick();
      end
      idle();
      #3;
      chk("ready_after_reclear", W'(ready), 1);
      for (int a = 0; a < DEPTH; a++) begin
         for (int i = 0; i < NRD; i++) ra[i] = AW'(a);
         dbg_addr = AW'(a);
         #3;
         chk($sformatf("zero_r%0d", a), rdata[0 +: W], 0);
         chk($sformatf("zero_dbg%0d", a), dbg_data, 0);
         tick();
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
